rbt_s_tx_table_lookup: RTL
==========================

Name: rbt_s_tx_table_lookup

Overview:
- Stage directly downstream of the RBT-S post-parser.
- Consumes parsed header, length and 272-bit packet metadata; inspects the TX-table-mask flag (metadata bit 239 = PKT_OP 232 + index 7).
- If the flag is set: extracts a key from the header, performs one request/response lookup against the external TX table, and merges hit/result into the metadata. If clear: passes the header unchanged.
- Single-entry, registered, blocking stage between parser and TX engine.

Parameters:
HEADER_WIDTH, 2048, header bus width in bits; must be a multiple of 8
PKT_METADATA_WIDTH, 272, metadata width in bits
KEY_WIDTH, 128, lookup key width in bits; multiple of 8
KEY_OFFSET, 0, byte offset of key in header; byte 0 = header MSBs
RESULT_WIDTH, 32, TX table result width
RESULT_LSB, 200, metadata LSB where result is written; RESULT_LSB+RESULT_WIDTH must be ≤ 232
TIMEOUT_CYCLES, 255, max cycles waiting for a response; 1..65535

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_proto_hdr_valid  in  1  input header valid
in_proto_hdr_ready  out  1  input header ready
in_proto_hdr_length  in  16  header length in bytes
in_proto_hdr_pkt_metadata  in  PKT_METADATA_WIDTH  metadata
in_proto_hdr_data  in  HEADER_WIDTH  header
lookup_req_valid  out  1  lookup request valid
lookup_req_ready  in  1  lookup request ready
lookup_req_key  out  KEY_WIDTH  lookup key
lookup_resp_valid  in  1  response strobe; no backpressure
lookup_resp_hit  in  1  table hit
lookup_resp_data  in  RESULT_WIDTH  table result
out_proto_hdr_valid  out  1  output valid
out_proto_hdr_ready  in  1  output ready
out_proto_hdr_data  out  HEADER_WIDTH  header, unmodified
out_proto_hdr_pkt_metadata  out  PKT_METADATA_WIDTH  updated metadata
out_proto_hdr_length  out  16  length, unmodified
stat_timeout_count  out  32  saturating count of lookup timeouts

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - All outputs 0: valid/ready strobes, key, data, metadata, length, stat_timeout_count.
  - Exception: in_proto_hdr_ready = 1 once rst deasserts.
  - Reset mid-operation abandons the held packet and any outstanding request; no output is produced for it.
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE:
  - in_proto_hdr_ready = 1; no other state asserts it.
  - On accept, register data/length/metadata.
  - Key = in_proto_hdr_data[HEADER_WIDTH-1-8*KEY_OFFSET -: KEY_WIDTH], registered.
  - Metadata bit 239 = 1 → REQ; otherwise → OUT with metadata unchanged.
- REQ:
  - lookup_req_valid = 1 with a stable key until lookup_req_ready.
  - On handshake → WAIT; timeout counter cleared.
- WAIT:
  - Counter increments each cycle.
  - lookup_resp_valid=1, hit=1: metadata[RESULT_LSB +: RESULT_WIDTH] = resp_data; metadata bit 238 (miss) = 0; → OUT.
  - lookup_resp_valid=1, hit=0: result field = 0; bit 238 = 1; → OUT.
  - Counter reaches TIMEOUT_CYCLES with no response: treated as miss (result 0, bit 238 = 1); stat_timeout_count +1, saturating at 0xFFFFFFFF; → OUT.
  - Response and timeout in the same cycle: response wins; no timeout counted.
- OUT:
  - out_proto_hdr_valid = 1; all out_* held stable until out_proto_hdr_ready.
  - On handshake → IDLE.
- All metadata bits other than the result field and bit 238 pass through unchanged, including bit 239.
- lookup_resp_valid outside WAIT is ignored and discarded (late responses after timeout).
- Latency, bypass: out_valid asserted the cycle after input accept.
- Latency, lookup: lookup_req_valid the cycle after accept; out_valid the cycle after the response or timeout cycle.
- Throughput, bypass: one packet per 2 cycles. There is no back-to-back acceptance while OUT is occupied.

Test Plan:
1. Bypass: accept metadata with bit239=0, length 0x0040 → out_valid one cycle later; data, length and metadata bit-exact; lookup_req_valid never asserted.
2. Hit: bit239=1, header top 128 bits = 0x0011…FF → lookup_req_key = 0x0011…FF. Respond 3 cycles after req handshake with hit=1, data=0xDEADBEEF → metadata[231:200] = 0xDEADBEEF, bit238 = 0.
3. Miss plus backpressure: hold lookup_req_ready=0 for 5 cycles, then respond hit=0 → req/key stable throughout; result field 0, bit238 = 1. Then hold out_ready=0 for 4 cycles → outputs stable and in_ready = 0.
4. Timeout: TIMEOUT_CYCLES=8, no response → out_valid 9 cycles after req handshake; bit238 = 1; stat_timeout_count = 1. A late resp_valid in IDLE → no effect.
5. Simultaneous: response arrives in the timeout cycle with hit=1, data=0x12345678 → result = 0x12345678; stat_timeout_count unchanged.
6. Async reset asserted in WAIT → all outputs 0 immediately. After release, a new bypass packet passes correctly and the old packet never appears.

Source files
------------

// File: rtl/rbt_s_tx_table_lookup.sv
// Single-entry registered stage between the RBT-S post-parser and the TX engine.
// Packets flagged in metadata bit 239 get one TX-table lookup merged into their metadata.
module rbt_s_tx_table_lookup #(
  parameter int HEADER_WIDTH       = 2048,
  parameter int PKT_METADATA_WIDTH = 272,
  parameter int KEY_WIDTH          = 128,
  parameter int KEY_OFFSET         = 0,
  parameter int RESULT_WIDTH       = 32,
  parameter int RESULT_LSB         = 200,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_proto_hdr_valid,
  output logic                          in_proto_hdr_ready,
  input  logic [15:0]                   in_proto_hdr_length,
  input  logic [PKT_METADATA_WIDTH-1:0] in_proto_hdr_pkt_metadata,
  input  logic [HEADER_WIDTH-1:0]       in_proto_hdr_data,
  output logic                          lookup_req_valid,
  input  logic                          lookup_req_ready,
  output logic [KEY_WIDTH-1:0]          lookup_req_key,
  input  logic                          lookup_resp_valid,
  input  logic                          lookup_resp_hit,
  input  logic [RESULT_WIDTH-1:0]       lookup_resp_data,
  output logic                          out_proto_hdr_valid,
  input  logic                          out_proto_hdr_ready,
  output logic [HEADER_WIDTH-1:0]       out_proto_hdr_data,
  output logic [PKT_METADATA_WIDTH-1:0] out_proto_hdr_pkt_metadata,
  output logic [15:0]                   out_proto_hdr_length,
  output logic [31:0]                   stat_timeout_count
);

  localparam int          FLAG_BIT      = 239;
  localparam int          MISS_BIT      = 238;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [HEADER_WIDTH-1:0]       data_q, data_d;
  logic [15:0]                   len_q, len_d;
  logic [PKT_METADATA_WIDTH-1:0] meta_q, meta_d;
  logic [KEY_WIDTH-1:0]          key_q, key_d;
  logic [15:0]                   cnt_q, cnt_d;
  logic [31:0]                   stat_q, stat_d;
  logic                          req_valid_q, req_valid_d;
  logic                          out_valid_q, out_valid_d;

  // Next-state, packet capture and lookup-result merge
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    meta_d  = meta_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    stat_d  = stat_q;
    case (state_q)
      S_IDLE: begin
        if (in_proto_hdr_valid) begin
          data_d  = in_proto_hdr_data;
          len_d   = in_proto_hdr_length;
          meta_d  = in_proto_hdr_pkt_metadata;
          key_d   = in_proto_hdr_data[HEADER_WIDTH-1-8*KEY_OFFSET -: KEY_WIDTH];
          state_d = in_proto_hdr_pkt_metadata[FLAG_BIT] ? S_REQ : S_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (lookup_req_ready) begin
          cnt_d   = 16'd0;
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        // A response in the timeout cycle takes priority and is not counted as a timeout.
        if (lookup_resp_valid) begin
          meta_d[RESULT_LSB +: RESULT_WIDTH] = lookup_resp_hit ? lookup_resp_data
                                                               : {RESULT_WIDTH{1'b0}};
          meta_d[MISS_BIT] = ~lookup_resp_hit;
          state_d          = S_OUT;
        end else if (cnt_q >= TIMEOUT_LIMIT) begin
          meta_d[RESULT_LSB +: RESULT_WIDTH] = {RESULT_WIDTH{1'b0}};
          meta_d[MISS_BIT] = 1'b1;
          if (stat_q != 32'hFFFF_FFFF) begin
            stat_d = stat_q + 32'd1;
          end else begin
            stat_d = stat_q;
          end
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_OUT: begin
        if (out_proto_hdr_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_valid_d = (state_d == S_REQ);
    out_valid_d = (state_d == S_OUT);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= {HEADER_WIDTH{1'b0}};
      len_q       <= 16'd0;
      meta_q      <= {PKT_METADATA_WIDTH{1'b0}};
      key_q       <= {KEY_WIDTH{1'b0}};
      cnt_q       <= 16'd0;
      stat_q      <= 32'd0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      len_q       <= len_d;
      meta_q      <= meta_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      stat_q      <= stat_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Ready is only meaningful in IDLE and is forced low while reset is held.
  assign in_proto_hdr_ready         = ~rst & (state_q == S_IDLE);
  assign lookup_req_valid           = req_valid_q;
  assign lookup_req_key             = key_q;
  assign out_proto_hdr_valid        = out_valid_q;
  assign out_proto_hdr_data         = data_q;
  assign out_proto_hdr_pkt_metadata = meta_q;
  assign out_proto_hdr_length       = len_q;
  assign stat_timeout_count         = stat_q;

endmodule
